lcd_cmd_seq: RTL

- Script-driven command sequencer for the LCD image-processing core.
- Fetches 4-bit opcodes from a command ROM and issues each one to the core over the cmd/cmd_valid/busy handshake.
- Issues the terminating WRITE opcode (0), then waits for the core's done pulse.
- Sits between the system test controller (start, status) and the LCD core. It replaces the bench-driven command stream.

---
 rtl/lcd_cmd_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_seq.sv
// Walks a 4-bit opcode script from the command ROM and issues each opcode to the LCD core.
// First cmd_valid 3 cycles after start; stalls in ISSUE/WAIT_BUSY while the core holds busy.
module lcd_cmd_seq #(
    parameter int SCRIPT_LEN   = 32,
    parameter int ADDR_W       = 5,
    parameter int DONE_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CMDROM_rd,
    output logic [ADDR_W-1:0] CMDROM_A,
    input  logic [3:0]        CMDROM_Q,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              lcd_done,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              err,
    output logic [ADDR_W:0]   cmd_cnt
);
    localparam int                TO_W    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(SCRIPT_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(DONE_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   CNT_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_Q,
        S_ISSUE,
        S_GUARD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH,
        S_ERR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [3:0]        r_cmd, w_cmd_nxt;
    logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
    logic [TO_W-1:0]   r_to, w_to_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              w_issue;
    logic              w_advance;

    assign w_issue = (r_state == S_ISSUE) && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cmd   <= '0;
            r_cnt   <= '0;
            r_to    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cmd   <= w_cmd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_to    <= w_to_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = '0;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE, S_FINISH, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT_Q;
            S_WAIT_Q: begin
                w_cmd_nxt = CMDROM_Q;
                // Opcodes 12-15 are no-ops for the core and never reach it
                if (CMDROM_Q >= 4'd12) begin
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue) begin
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + (ADDR_W + 1)'(1);
                    end
                    w_state_nxt = (r_cmd == 4'd0) ? S_WAIT_DONE : S_GUARD;
                end
            end
            // The core may not raise busy until the cycle after it accepts a command
            S_GUARD: w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!busy) begin
                    w_advance = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (lcd_done) begin
                    w_state_nxt = S_FINISH;
                    w_done_nxt  = 1'b1;
                end else if (r_to == TO_LAST) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_to_nxt = r_to + TO_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_addr == LAST_A) begin
                w_state_nxt = S_ERR;
                w_err_nxt   = 1'b1;
            end else begin
                w_addr_nxt  = r_addr + ADDR_W'(1);
                w_state_nxt = S_FETCH;
            end
        end
    end

    assign CMDROM_rd = (r_state == S_FETCH);
    assign CMDROM_A  = r_addr;
    assign cmd       = r_cmd;
    assign cmd_valid = w_issue;
    assign seq_busy  = !((r_state == S_IDLE) || (r_state == S_FINISH) || (r_state == S_ERR));
    assign seq_done  = r_done;
    assign err       = r_err;
    assign cmd_cnt   = r_cnt;

endmodule
